// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
//   word_t      : architectural data word.
//   aluop_t     : operation select for the combinational ALU.
//   muldiv_op_t : operation select for the iterative multiply/divide unit.
// Helper functions classify muldiv_op_t values so decode logic stays readable.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  function automatic logic md_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Signal bundle between the execute stage and the multiply/divide unit.
//   start/op/A/B  : operation request (sampled by the unit only when idle)
//   hi_wen/lo_wen : MTHI/MTLO write enables, data on wdat
//   busy/done     : operation in flight / one-cycle completion pulse
//   HI/LO         : architectural HI/LO registers
// Modport md is the unit side, tb is the requester side.
interface muldiv_if;
  import cpu_types_pkg::*;

  logic       start;
  muldiv_op_t op;
  word_t      A;
  word_t      B;
  logic       hi_wen;
  logic       lo_wen;
  word_t      wdat;
  logic       busy;
  logic       done;
  word_t      HI;
  word_t      LO;

  modport md (
    input  start, op, A, B, hi_wen, lo_wen, wdat,
    output busy, done, HI, LO
  );

  modport tb (
    output start, op, A, B, hi_wen, lo_wen, wdat,
    input  busy, done, HI, LO
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU; owns HI/LO.
// Ports:
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : muldiv_if.md (request, MTHI/MTLO writes, busy/done, HI/LO)
// Operands are reduced to magnitudes on issue, processed for 32 cycles
// (shift-add multiply or restoring divide through one shared 33-bit adder),
// then sign-corrected and written to HI/LO in a final FIX cycle.
module muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic  CLK,
  input logic  nRST,
  muldiv_if.md bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [4:0]       cnt_reg;
  muldiv_op_t       op_reg;
  // Adder operand: multiplicand magnitude for multiply, divisor for divide.
  logic [WIDTH-1:0] opnd_reg;
  // Product high half for multiply; 33-bit partial remainder for divide.
  logic [WIDTH:0]   acc_hi_reg;
  // Multiplier shifting out / product low half, or dividend shifting out /
  // quotient shifting in.
  logic [WIDTH-1:0] acc_lo_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             busy_reg;
  logic             done_reg;
  word_t            hi_reg;
  word_t            lo_reg;

  // Issue-time operand conditioning
  logic             in_signed;
  logic             in_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    in_signed = md_is_signed(bus.op);
    in_div    = md_is_div(bus.op);
    // -0x80000000 wraps to itself, which is the correct unsigned magnitude.
    a_mag     = (in_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag     = (in_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  end

  // Shared adder: add for multiply, subtract (a + ~b + 1) for divide.
  logic             op_div;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   acc_hi_next;
  logic [WIDTH-1:0] acc_lo_next;

  assign op_div = md_is_div(op_reg);

  always_comb begin
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;
    acc_hi_next = acc_hi_reg;
    acc_lo_next = acc_lo_reg;
    if (op_div) begin
      // Shift the next dividend bit into the remainder, then trial-subtract.
      add_a   = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
      add_b   = ~{1'b0, opnd_reg};
      add_cin = 1'b1;
    end else begin
      add_a   = acc_hi_reg;
      add_b   = acc_lo_reg[0] ? {1'b0, opnd_reg} : '0;
      add_cin = 1'b0;
    end
    add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
    if (op_div) begin
      // The remainder is always below the divisor, so a set MSB on the
      // 33-bit difference means the trial went negative: restore.
      acc_hi_next = add_sum[WIDTH] ? add_a : add_sum;
      acc_lo_next = {acc_lo_reg[WIDTH-2:0], ~add_sum[WIDTH]};
    end else begin
      // Shift the 65-bit {carry, acc_hi, acc_lo} right by one.
      acc_hi_next = {1'b0, add_sum[WIDTH:1]};
      acc_lo_next = {add_sum[0], acc_lo_reg[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_mag = {acc_hi_reg[WIDTH-1:0], acc_lo_reg};
    prod_fix = sign_q_reg ? -prod_mag : prod_mag;
    quo_fix  = sign_q_reg ? -acc_lo_reg : acc_lo_reg;
    rem_fix  = sign_r_reg ? -acc_hi_reg[WIDTH-1:0] : acc_hi_reg[WIDTH-1:0];
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt_reg == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and architectural registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_reg    <= '0;
      op_reg     <= MD_MULT;
      opnd_reg   <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_reg == FIX);
      case (state_reg)
        IDLE: begin
          if (bus.hi_wen) hi_reg <= bus.wdat;
          if (bus.lo_wen) lo_reg <= bus.wdat;
          if (bus.start) begin
            op_reg     <= bus.op;
            cnt_reg    <= '0;
            sign_q_reg <= in_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            sign_r_reg <= in_signed & bus.A[WIDTH-1];
            opnd_reg   <= in_div ? b_mag : a_mag;
            acc_lo_reg <= in_div ? a_mag : b_mag;
            acc_hi_reg <= '0;
          end
        end
        CALC: begin
          cnt_reg    <= cnt_reg + 5'd1;
          acc_hi_reg <= acc_hi_next;
          acc_lo_reg <= acc_lo_next;
        end
        FIX: begin
          if (op_div) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, busy/reset/MTHI/MTLO
// behaviour and a randomised sweep against a 64-bit reference model, with
// expected results queued at issue and compared at the done pulse.
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  muldiv_if md_bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK  (clk),
    .nRST (n_rst),
    .bus  (md_bus)
  );

  typedef struct {
    muldiv_op_t op;
    word_t      a;
    word_t      b;
    word_t      hi;
    word_t      lo;
  } exp_t;

  exp_t  sb_q[$];
  int    assert_count = 0;
  int    fail_count = 0;
  word_t last_hi;
  word_t last_lo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string op_name(input muldiv_op_t op);
    case (op)
      MD_MULT:  return "MULT";
      MD_MULTU: return "MULTU";
      MD_DIV:   return "DIV";
      default:  return "DIVU";
    endcase
  endfunction

  // Reference: 64-bit arithmetic, truncating signed division; a zero
  // divisor yields magnitude quotient all-ones and remainder |A|, signed.
  function automatic void model(input muldiv_op_t op, input word_t a, input word_t b,
                                output word_t hi, output word_t lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT: begin
        sq = sa * sb;
        hi = sq[63:32];
        lo = sq[31:0];
      end
      MD_MULTU: begin
        uq = ua * ub;
        hi = uq[63:32];
        lo = uq[31:0];
      end
      MD_DIV: begin
        if (b == 32'h0) begin
          lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
          hi = a;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          lo = sq[31:0];
          hi = sr[31:0];
        end
      end
      default: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          lo = uq[31:0];
          hi = ur[31:0];
        end
      end
    endcase
  endfunction

  function automatic word_t rnd_word();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  // Called at a negedge; drives start immediately and follows the operation
  // to its done pulse. With intrude set, a DIVU start and an MTHI write are
  // attempted in cycle 10 while the unit is busy.
  task automatic run_op(input muldiv_op_t op, input word_t a, input word_t b, input bit intrude);
    exp_t e;
    exp_t got_e;
    int   cycles;
    int   busy_cycles;
    bit   seen;
    e.op = op;
    e.a  = a;
    e.b  = b;
    model(op, a, b, e.hi, e.lo);
    sb_q.push_back(e);
    md_bus.start = 1'b1;
    md_bus.op    = op;
    md_bus.A     = a;
    md_bus.B     = b;
    cycles      = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      md_bus.start  = 1'b0;
      md_bus.hi_wen = 1'b0;
      if (intrude && cycles == 11)
        check_eq("hi_wen_while_busy", md_bus.HI, last_hi);
      if (intrude && cycles == 10) begin
        md_bus.start  = 1'b1;
        md_bus.op     = MD_DIVU;
        md_bus.A      = 32'h0000_0100;
        md_bus.B      = 32'h0000_0003;
        md_bus.hi_wen = 1'b1;
        md_bus.wdat   = 32'h0000_1234;
      end
      if (md_bus.busy) busy_cycles++;
      if (md_bus.done) begin
        seen = 1'b1;
        check_eq("done_with_busy", md_bus.busy, 1'b0);
        check_eq("scoreboard_has_entry", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          got_e = sb_q.pop_front();
          check_eq({op_name(got_e.op), " HI"}, md_bus.HI, got_e.hi);
          check_eq({op_name(got_e.op), " LO"}, md_bus.LO, got_e.lo);
          check_eq("latency", cycles, 34);
          check_eq("busy_cycles", busy_cycles, 33);
          last_hi = got_e.hi;
          last_lo = got_e.lo;
          $display("%-5s A=%08h B=%08h -> HI=%08h LO=%08h (done after %0d cycles, busy %0d)",
                   op_name(got_e.op), got_e.a, got_e.b, md_bus.HI, md_bus.LO, cycles, busy_cycles);
        end
      end
    end
    check_eq("done_within_budget", seen, 1'b1);
  endtask

  int         op_fail_base;
  muldiv_op_t sweep_op;

  initial begin
    md_bus.start  = 1'b0;
    md_bus.op     = MD_MULT;
    md_bus.A      = '0;
    md_bus.B      = '0;
    md_bus.hi_wen = 1'b0;
    md_bus.lo_wen = 1'b0;
    md_bus.wdat   = '0;
    n_rst         = 1'b0;
    last_hi       = '0;
    last_lo       = '0;

    repeat (3) @(negedge clk);
    check_eq("reset busy", md_bus.busy, 1'b0);
    check_eq("reset done", md_bus.done, 1'b0);
    check_eq("reset HI", md_bus.HI, 32'h0);
    check_eq("reset LO", md_bus.LO, 32'h0);
    $display("reset: busy=%0b done=%0b HI=%08h LO=%08h", md_bus.busy, md_bus.done, md_bus.HI, md_bus.LO);
    n_rst = 1'b1;
    @(negedge clk);

    // Directed arithmetic; consecutive calls issue in the done cycle.
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    run_op(MD_MULT, -32'sd3, 32'sd5, 1'b0);
    run_op(MD_DIV, -32'sd7, 32'sd2, 1'b0);
    run_op(MD_DIVU, 32'd100, 32'd0, 1'b0);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);

    // Start and MTHI while busy are ignored; next op issued back-to-back.
    run_op(MD_MULTU, 32'd6, 32'd7, 1'b1);
    run_op(MD_DIVU, 32'd1000, 32'd7, 1'b0);

    // HI/LO hold while idle
    repeat (3) @(negedge clk);
    check_eq("hold HI", md_bus.HI, last_hi);
    check_eq("hold LO", md_bus.LO, last_lo);
    $display("idle hold: HI=%08h LO=%08h", md_bus.HI, md_bus.LO);

    // MTLO then MTHI, each visible one cycle later
    md_bus.lo_wen = 1'b1;
    md_bus.wdat   = 32'hDEAD_BEEF;
    @(negedge clk);
    md_bus.lo_wen = 1'b0;
    check_eq("mtlo LO", md_bus.LO, 32'hDEAD_BEEF);
    check_eq("mtlo HI", md_bus.HI, last_hi);
    last_lo = 32'hDEAD_BEEF;
    $display("MTLO wdat=DEADBEEF -> HI=%08h LO=%08h", md_bus.HI, md_bus.LO);
    md_bus.hi_wen = 1'b1;
    md_bus.wdat   = 32'hCAFE_F00D;
    @(negedge clk);
    md_bus.hi_wen = 1'b0;
    check_eq("mthi HI", md_bus.HI, 32'hCAFE_F00D);
    check_eq("mthi LO", md_bus.LO, last_lo);
    last_hi = 32'hCAFE_F00D;
    $display("MTHI wdat=CAFEF00D -> HI=%08h LO=%08h", md_bus.HI, md_bus.LO);

    // Reset in cycle 15 of a DIV aborts it
    md_bus.start = 1'b1;
    md_bus.op    = MD_DIV;
    md_bus.A     = -32'sd1000;
    md_bus.B     = 32'sd3;
    @(negedge clk);
    md_bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("busy before abort", md_bus.busy, 1'b1);
    n_rst = 1'b0;
    #1;
    check_eq("abort busy", md_bus.busy, 1'b0);
    check_eq("abort done", md_bus.done, 1'b0);
    check_eq("abort HI", md_bus.HI, 32'h0);
    check_eq("abort LO", md_bus.LO, 32'h0);
    $display("reset mid-DIV: busy=%0b HI=%08h LO=%08h", md_bus.busy, md_bus.HI, md_bus.LO);
    @(negedge clk);
    n_rst   = 1'b1;
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    check_eq("post-abort busy", md_bus.busy, 1'b0);
    run_op(MD_DIV, -32'sd1000, 32'sd3, 1'b0);

    // Randomised sweep, 200 operations per op
    for (int k = 0; k < 4; k++) begin
      sweep_op     = muldiv_op_t'(k);
      op_fail_base = fail_count;
      for (int n = 0; n < 200; n++) begin
        run_op(sweep_op, rnd_word(), rnd_word(), 1'b0);
      end
      $display("sweep %-5s: 200 operations, %0d errors", op_name(sweep_op), fail_count - op_fail_base);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
